// File: rtl/risc16_pkg.sv
// Shared encodings for the risc16 control path: opcodes, mux selects, ALU ops, FSM states.
package risc16_pkg;

  localparam int unsigned OP_W   = 3;
  localparam int unsigned WAIT_W = 8;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 3'b000,
    OP_ADDI = 3'b001,
    OP_NAND = 3'b010,
    OP_LUI  = 3'b011,
    OP_LW   = 3'b100,
    OP_SW   = 3'b101,
    OP_BEQ  = 3'b110,
    OP_JALR = 3'b111
  } opcode_e;

  typedef enum logic [1:0] {
    TGT_MEM = 2'b00,
    TGT_ALU = 2'b01,
    TGT_PC1 = 2'b10
  } mux_tgt_e;

  typedef enum logic [1:0] {
    PC_INC = 2'b00,
    PC_BR  = 2'b01,
    PC_REG = 2'b10
  } pc_sel_e;

  typedef enum logic [1:0] {
    ALU_ADD  = 2'b00,
    ALU_NAND = 2'b01,
    ALU_PASS = 2'b10,
    ALU_CMP  = 2'b11
  } alu_op_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_FAULT  = 3'd6
  } state_e;

  // sw and beq compare/store rA, so the second read port must select rA
  function automatic logic reads_ra(opcode_e op);
    return (op == OP_SW) || (op == OP_BEQ);
  endfunction

  // ALU function required by each opcode
  function automatic alu_op_e alu_op_for(opcode_e op);
    case (op)
      OP_NAND: return ALU_NAND;
      OP_LUI:  return ALU_PASS;
      OP_BEQ:  return ALU_CMP;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts memory-handshake wait cycles; flags expiry on the cycle the count would reach LIMIT.
module mem_wait_timer
  import risc16_pkg::*;
#(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired_c
);

  logic [WAIT_W-1:0] cnt_q;

  // Wait-cycle counter; clear has priority so a new wait always starts from zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + WAIT_W'(1);
    end
  end

  // Only a cycle still waiting can expire, so ready on the last cycle wins
  assign expired_c = en && (cnt_q == WAIT_W'(LIMIT - 1));

endmodule

// File: rtl/risc16_control_fsm.sv
// Multi-cycle control unit: sequences fetch/decode/exec/mem/wb and drives RF, PC, ALU and memory strobes.
module risc16_control_fsm
  import risc16_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [OP_W-1:0]  opcode,
  input  logic             alu_eq,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             ir_we,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [1:0]       alu_op,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic [1:0]       MUX_tgt,
  output logic             MUX_rf,
  output logic             WE_rf,
  output logic [CNT_W-1:0] retired_cnt,
  output logic             fault,
  output logic             busy
);

  state_e  state_q, state_d;
  opcode_e op_q, op_cur;
  logic    retire_c;
  logic    wait_en_c, wait_clr_c, expired_c;

  // One shared timer serves both the fetch and the data waits
  assign wait_en_c  = ((state_q == S_FETCH) && !imem_ready) ||
                      ((state_q == S_MEM)   && !dmem_ready);
  assign wait_clr_c = (state_d != state_q);

  mem_wait_timer #(.LIMIT(MEM_TIMEOUT)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (wait_clr_c),
    .en        (wait_en_c),
    .expired_c (expired_c)
  );

  // State, latched opcode, retire counter and sticky fault
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= OP_ADD;
      retired_cnt <= '0;
      fault       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) op_q <= opcode_e'(opcode);
      if (retire_c) retired_cnt <= retired_cnt + CNT_W'(1);
      if (state_d == S_FAULT) fault <= 1'b1;
    end
  end

  // The IR only holds the new opcode from DECODE on; later states use the latched copy
  assign op_cur = (state_q == S_DECODE) ? opcode_e'(opcode) : op_q;

  // Next-state and strobe decode
  always_comb begin
    state_d  = state_q;
    retire_c = 1'b0;
    ir_we    = 1'b0;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    alu_op   = ALU_ADD;
    pc_we    = 1'b0;
    pc_sel   = PC_INC;
    MUX_tgt  = TGT_MEM;
    MUX_rf   = 1'b0;
    WE_rf    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else if (expired_c) begin
          state_d = S_FAULT;
        end
      end
      S_DECODE: begin
        MUX_rf  = reads_ra(op_cur);
        state_d = S_EXEC;
      end
      S_EXEC: begin
        MUX_rf = reads_ra(op_cur);
        alu_op = alu_op_for(op_cur);
        if (op_cur == OP_BEQ) begin
          pc_we    = 1'b1;
          pc_sel   = alu_eq ? PC_BR : PC_INC;
          retire_c = 1'b1;
        end else if ((op_cur == OP_LW) || (op_cur == OP_SW)) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        MUX_rf   = reads_ra(op_cur);
        alu_op   = alu_op_for(op_cur);
        dmem_req = 1'b1;
        dmem_we  = (op_cur == OP_SW);
        if (dmem_ready) begin
          if (op_cur == OP_SW) begin
            pc_we    = 1'b1;
            retire_c = 1'b1;
          end else begin
            state_d = S_WB;
          end
        end else if (expired_c) begin
          state_d = S_FAULT;
        end
      end
      S_WB: begin
        // ALU select held from EXEC so the written ALU result stays stable
        MUX_rf   = reads_ra(op_cur);
        alu_op   = alu_op_for(op_cur);
        WE_rf    = 1'b1;
        pc_we    = 1'b1;
        retire_c = 1'b1;
        if (op_cur == OP_JALR) begin
          MUX_tgt = TGT_PC1;
          pc_sel  = PC_REG;
        end else if (op_cur == OP_LW) begin
          MUX_tgt = TGT_MEM;
        end else begin
          MUX_tgt = TGT_ALU;
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase

    if (retire_c) state_d = run ? S_FETCH : S_IDLE;
  end

  assign busy = (state_q != S_IDLE) && (state_q != S_FAULT);

endmodule

// File: tb/tb_risc16_control_fsm.sv
// Directed bench: expands each instruction into its expected per-cycle outputs and checks every cycle.
module tb_risc16_control_fsm;

  localparam int unsigned TO = 4;
  localparam int unsigned CW = 4;

  bit          clk = 1'b0;
  logic        rst_n, run, alu_eq, imem_ready, dmem_ready;
  logic [2:0]  opcode;
  logic        ir_we, imem_req, dmem_req, dmem_we, pc_we, MUX_rf, WE_rf, fault, busy;
  logic [1:0]  alu_op, pc_sel, MUX_tgt;
  logic [CW-1:0] retired_cnt;

  risc16_control_fsm #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .alu_eq(alu_eq),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .ir_we(ir_we),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we), .alu_op(alu_op),
    .pc_we(pc_we), .pc_sel(pc_sel), .MUX_tgt(MUX_tgt), .MUX_rf(MUX_rf),
    .WE_rf(WE_rf), .retired_cnt(retired_cnt), .fault(fault), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic ir_we, imem_req, dmem_req, dmem_we, pc_we, we_rf, mux_rf, busy, fault;
    logic [1:0] alu_op, pc_sel, mux_tgt;
    bit chk_alu, chk_rf, chk_tgt, chk_sel;
  } exp_t;

  exp_t        e;
  bit          exp_valid = 1'b0;
  logic [CW-1:0] exp_cnt = '0;
  logic        mdl_fault = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          busy_cyc = 0;
  int          dreq_cyc = 0;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Every checked cycle: compare DUT against the model's expected vector
  always @(negedge clk) begin
    if (busy === 1'b1) busy_cyc++;
    if (dmem_req === 1'b1) dreq_cyc++;
    if (exp_valid) begin
      check("ir_we", 16'(ir_we), 16'(e.ir_we));
      check("imem_req", 16'(imem_req), 16'(e.imem_req));
      check("dmem_req", 16'(dmem_req), 16'(e.dmem_req));
      check("dmem_we", 16'(dmem_we), 16'(e.dmem_we));
      check("pc_we", 16'(pc_we), 16'(e.pc_we));
      check("WE_rf", 16'(WE_rf), 16'(e.we_rf));
      check("busy", 16'(busy), 16'(e.busy));
      check("fault", 16'(fault), 16'(e.fault));
      check("retired_cnt", 16'(retired_cnt), 16'(exp_cnt));
      if (e.chk_alu) check("alu_op", 16'(alu_op), 16'(e.alu_op));
      if (e.chk_rf)  check("MUX_rf", 16'(MUX_rf), 16'(e.mux_rf));
      if (e.chk_tgt) check("MUX_tgt", 16'(MUX_tgt), 16'(e.mux_tgt));
      if (e.chk_sel) check("pc_sel", 16'(pc_sel), 16'(e.pc_sel));
    end
  end

  function automatic exp_t quiet_exp();
    exp_t x;
    x = '{default: '0};
    x.chk_alu = 1'b1; x.chk_rf = 1'b1; x.chk_tgt = 1'b1; x.chk_sel = 1'b1;
    return x;
  endfunction

  function automatic exp_t busy_exp();
    exp_t x;
    x = '{default: '0};
    x.busy = 1'b1;
    return x;
  endfunction

  function automatic logic [1:0] m_alu(input logic [2:0] op);
    case (op)
      3'b010:  return 2'b01;
      3'b011:  return 2'b10;
      3'b110:  return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic m_rf(input logic [2:0] op);
    return (op == 3'b101) || (op == 3'b110);
  endfunction

  // Present one cycle of expectations; the retire edge advances the model's count
  task automatic cyc(input exp_t x, input bit retire);
    e = x;
    e.fault = mdl_fault;
    exp_valid = 1'b1;
    @(posedge clk); #1;
    if (retire) exp_cnt = exp_cnt + CW'(1);
  endtask

  task automatic idle_cyc(input logic r);
    run = r; imem_ready = 1'b1; dmem_ready = 1'b1;
    cyc(quiet_exp(), 1'b0);
  endtask

  // One instruction from its first FETCH cycle; iw/dw = wait cycles before ready
  task automatic run_instr(input logic [2:0] op, input int iw, input int dw,
                           input logic eq, input logic run_nxt, input bit stop_mem);
    exp_t x;
    logic is_mem, is_beq, is_sw;
    is_mem = (op == 3'b100) || (op == 3'b101);
    is_beq = (op == 3'b110);
    is_sw  = (op == 3'b101);
    run = run_nxt;
    alu_eq = ~eq;
    for (int k = 0; k <= iw; k++) begin
      imem_ready = (k == iw); dmem_ready = 1'b1; opcode = ~op;
      x = busy_exp(); x.imem_req = 1'b1; x.ir_we = (k == iw);
      cyc(x, 1'b0);
    end
    opcode = op; imem_ready = 1'b1;
    x = busy_exp(); x.mux_rf = m_rf(op); x.chk_rf = 1'b1;
    cyc(x, 1'b0);
    opcode = ~op; alu_eq = eq;
    x = busy_exp(); x.mux_rf = m_rf(op); x.chk_rf = 1'b1;
    x.alu_op = m_alu(op); x.chk_alu = 1'b1;
    if (is_beq) begin
      x.pc_we = 1'b1; x.pc_sel = eq ? 2'b01 : 2'b00; x.chk_sel = 1'b1;
    end
    cyc(x, is_beq);
    alu_eq = ~eq;
    if (is_mem) begin
      if (stop_mem) begin
        dmem_ready = 1'b0;
        exp_valid = 1'b0;
        #1 check("dmem_req_mid_mem", 16'(dmem_req), 16'd1);
        #2 rst_n = 1'b0;
        #1 check_reset();
        return;
      end
      for (int k = 0; k <= dw; k++) begin
        dmem_ready = (k == dw); imem_ready = 1'b1;
        x = busy_exp(); x.dmem_req = 1'b1; x.dmem_we = is_sw;
        x.mux_rf = m_rf(op); x.chk_rf = 1'b1;
        if (is_sw && (k == dw)) begin
          x.pc_we = 1'b1; x.pc_sel = 2'b00; x.chk_sel = 1'b1;
        end
        cyc(x, is_sw && (k == dw));
      end
    end
    if (!is_beq && !is_sw) begin
      x = busy_exp(); x.we_rf = 1'b1; x.pc_we = 1'b1; x.chk_tgt = 1'b1; x.chk_sel = 1'b1;
      x.mux_rf = m_rf(op); x.chk_rf = 1'b1;
      if (op == 3'b111) begin
        x.mux_tgt = 2'b10; x.pc_sel = 2'b10;
      end else if (op == 3'b100) begin
        x.mux_tgt = 2'b00; x.pc_sel = 2'b00;
      end else begin
        x.mux_tgt = 2'b01; x.pc_sel = 2'b00;
      end
      cyc(x, 1'b1);
    end
  endtask

  task automatic check_reset();
    check("rst_ir_we", 16'(ir_we), 16'd0);
    check("rst_imem_req", 16'(imem_req), 16'd0);
    check("rst_dmem_req", 16'(dmem_req), 16'd0);
    check("rst_dmem_we", 16'(dmem_we), 16'd0);
    check("rst_pc_we", 16'(pc_we), 16'd0);
    check("rst_WE_rf", 16'(WE_rf), 16'd0);
    check("rst_alu_op", 16'(alu_op), 16'd0);
    check("rst_pc_sel", 16'(pc_sel), 16'd0);
    check("rst_MUX_tgt", 16'(MUX_tgt), 16'd0);
    check("rst_MUX_rf", 16'(MUX_rf), 16'd0);
    check("rst_retired_cnt", 16'(retired_cnt), 16'd0);
    check("rst_fault", 16'(fault), 16'd0);
    check("rst_busy", 16'(busy), 16'd0);
  endtask

  initial begin
    int b0, d0;
    rst_n = 1'b0; run = 1'b0; opcode = 3'b000; alu_eq = 1'b0;
    imem_ready = 1'b0; dmem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_reset();
    rst_n = 1'b1;
    idle_cyc(1'b0);
    idle_cyc(1'b1);

    b0 = busy_cyc;
    run_instr(3'b000, 0, 0, 1'b0, 1'b1, 1'b0);             // add
    check("lit_add_cycles", 16'(busy_cyc - b0), 16'd4);
    check("lit_cnt_after_add", 16'(retired_cnt), 16'd1);
    d0 = dreq_cyc;
    run_instr(3'b100, 0, 3, 1'b0, 1'b1, 1'b0);             // lw, 3 data waits
    check("lit_lw_dmem_req_cycles", 16'(dreq_cyc - d0), 16'd4);
    b0 = busy_cyc;
    run_instr(3'b100, 0, 0, 1'b0, 1'b1, 1'b0);             // lw
    check("lit_lw_cycles", 16'(busy_cyc - b0), 16'd5);
    b0 = busy_cyc;
    run_instr(3'b101, 0, 0, 1'b0, 1'b1, 1'b0);             // sw
    check("lit_sw_cycles", 16'(busy_cyc - b0), 16'd4);
    run_instr(3'b101, 1, 2, 1'b0, 1'b1, 1'b0);             // sw with waits
    run_instr(3'b110, 0, 0, 1'b1, 1'b1, 1'b0);             // beq taken
    run_instr(3'b110, 0, 0, 1'b0, 1'b1, 1'b0);             // beq not taken
    run_instr(3'b111, 0, 0, 1'b0, 1'b1, 1'b0);             // jalr
    run_instr(3'b010, 0, 0, 1'b0, 1'b1, 1'b0);             // nand
    run_instr(3'b011, 0, 0, 1'b0, 1'b1, 1'b0);             // lui
    run_instr(3'b001, 3, 0, 1'b0, 1'b1, 1'b0);             // addi, ready on last allowed cycle
    check("lit_cnt_after_11", 16'(retired_cnt), 16'd11);
    for (int i = 0; i < 5; i++)
      run_instr(3'b000, 0, 0, 1'b0, (i != 4), 1'b0);
    check("lit_cnt_wrap", 16'(retired_cnt), 16'd0);
    idle_cyc(1'b0);
    idle_cyc(1'b1);

    // Reset while waiting on data memory
    run_instr(3'b100, 0, 0, 1'b0, 1'b1, 1'b1);
    exp_cnt = '0; mdl_fault = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    idle_cyc(1'b1);

    // Fetch timeout: four unanswered cycles, then sticky fault
    for (int k = 0; k < int'(TO); k++) begin
      exp_t x;
      imem_ready = 1'b0; dmem_ready = 1'b1;
      x = busy_exp(); x.imem_req = 1'b1;
      cyc(x, 1'b0);
    end
    mdl_fault = 1'b1;
    for (int k = 0; k < 3; k++) idle_cyc(1'b1);
    check("lit_fault_sticky", 16'(fault), 16'd1);

    exp_valid = 1'b0;
    rst_n = 1'b0;
    #1 check_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
